prbs_link_monitor: RTL and testbench

Pattern generator and error checker for the transceiver loopback test. Drives the PRBS7 transmit word stream and checks the received stream. Reports lock, sticky error, data-valid and a 32-bit error count as status to the fabric UART command block. Takes its start, clear and error-inject controls from that same UART command block.

---
 rtl/prbs_link_monitor.sv | 189 ++++++++++++++++++
 tb/tb_prbs_link_monitor.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/prbs_link_monitor.sv
// PRBS7 loopback generator/checker with lock FSM, sticky error flag and saturating error count.
// Optional word-error injection on genrate_err is compiled in with PRBS_ERR_INJECT_EN.
module prbs_link_monitor #(
  parameter int DATA_W   = 16,
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic              genrate_err,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_data_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              rx_val,
  output logic              rx_lock,
  output logic              rx_error,
  output logic [31:0]       error_count
);

  typedef enum logic [1:0] {IDLE, SEED, TRAIN, LOCKED} state_t;

  // Generator word: the bit shifted out of s[6] on each of DATA_W steps.
  function automatic logic [DATA_W-1:0] gen_word(input logic [6:0] s);
    logic [DATA_W-1:0] w;
    logic [6:0]        t;
    t = s;
    w = '0;
    for (int i = DATA_W-1; i >= 0; i--) begin
      w[i] = t[6];
      t    = {t[5:0], t[6] ^ t[5]};
    end
    return w;
  endfunction

  function automatic logic [6:0] gen_next(input logic [6:0] s);
    logic [6:0] t;
    t = s;
    for (int i = 0; i < DATA_W; i++) t = {t[5:0], t[6] ^ t[5]};
    return t;
  endfunction

  // Checker view: state holds the last 7 stream bits, so the next word is the feedback bits.
  function automatic logic [DATA_W-1:0] pred_word(input logic [6:0] s);
    logic [DATA_W-1:0] w;
    logic [6:0]        t;
    t = s;
    w = '0;
    for (int i = DATA_W-1; i >= 0; i--) begin
      w[i] = t[6] ^ t[5];
      t    = {t[5:0], w[i]};
    end
    return w;
  endfunction

  logic [6:0]        lfsr;
  logic [DATA_W-1:0] inj_mask;

`ifdef PRBS_ERR_INJECT_EN
  logic err_d, inj_pend, inj;
  // A rising edge seen while start=0 waits for the next emitted word.
  assign inj      = (genrate_err & ~err_d) | inj_pend;
  assign inj_mask = {{(DATA_W-1){1'b0}}, inj};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_d    <= 1'b0;
      inj_pend <= 1'b0;
    end else begin
      err_d    <= genrate_err;
      inj_pend <= start ? 1'b0 : inj;
    end
  end
`else
  logic unused_genrate_err;
  assign unused_genrate_err = genrate_err;
  assign inj_mask           = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr     <= 7'h7F;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= start;
      if (start) begin
        lfsr    <= gen_next(lfsr);
        tx_data <= gen_word(lfsr) ^ inj_mask;
      end
    end
  end

  state_t            state, state_n;
  logic [6:0]        pred_st, pred_st_n;
  logic [7:0]        good, good_n, bad, bad_n;
  logic [DATA_W-1:0] pred;
  logic              match, cnt_err;

  assign pred  = pred_word(pred_st);
  assign match = (rx_data == pred);

  always_comb begin
    state_n   = state;
    pred_st_n = pred_st;
    good_n    = good;
    bad_n     = bad;
    cnt_err   = 1'b0;
    if (!start) begin
      state_n = IDLE;
      good_n  = '0;
      bad_n   = '0;
    end else if (rx_data_valid) begin
      case (state)
        IDLE, SEED: begin
          pred_st_n = rx_data[6:0];
          good_n    = '0;
          bad_n     = '0;
          // An all-zero seed would lock the predictor at zero.
          state_n   = (rx_data[6:0] == 7'd0) ? SEED : TRAIN;
        end
        TRAIN: begin
          if (match) begin
            pred_st_n = pred[6:0];
            good_n    = good + 8'd1;
            if (good == 8'(LOCK_CNT-1)) begin
              state_n = LOCKED;
              good_n  = '0;
              bad_n   = '0;
            end
          end else begin
            good_n  = '0;
            state_n = SEED;
          end
        end
        LOCKED: begin
          pred_st_n = pred[6:0];
          if (match) begin
            bad_n = '0;
          end else begin
            cnt_err = 1'b1;
            bad_n   = bad + 8'd1;
            if (bad == 8'(LOSS_CNT-1)) begin
              state_n = SEED;
              bad_n   = '0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pred_st <= 7'h7F;
      good    <= '0;
      bad     <= '0;
    end else begin
      state   <= state_n;
      pred_st <= pred_st_n;
      good    <= good_n;
      bad     <= bad_n;
    end
  end

  assign rx_lock = (state == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_val      <= 1'b0;
      rx_error    <= 1'b0;
      error_count <= '0;
    end else begin
      rx_val <= rx_data_valid;
      if (clear) begin
        rx_error    <= 1'b0;
        error_count <= '0;
      end else if (cnt_err) begin
        rx_error <= 1'b1;
        if (error_count != 32'hFFFF_FFFF) error_count <= error_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_link_monitor.sv
// Directed loopback bench for prbs_link_monitor (DATA_W=16, LOCK_CNT=16, LOSS_CNT=4).
module tb_prbs_link_monitor;
  localparam int DW = 16;
`ifdef PRBS_ERR_INJECT_EN
  localparam logic [31:0] INJ = 32'd1;
`else
  localparam logic [31:0] INJ = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, clear, genrate_err, zero_rx;
  logic [DW-1:0] rx_data, tx_data;
  logic          rx_data_valid, tx_valid, rx_val, rx_lock, rx_error;
  logic [31:0]   error_count;
  int            n_total = 0;
  int            n_bad   = 0;

  always #5 clk = ~clk;

  assign rx_data       = zero_rx ? '0 : tx_data;
  assign rx_data_valid = tx_valid;

  prbs_link_monitor #(.DATA_W(DW), .LOCK_CNT(16), .LOSS_CNT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .genrate_err(genrate_err),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .rx_val(rx_val), .rx_lock(rx_lock), .rx_error(rx_error), .error_count(error_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Seed word plus 16 good words; lock shows only after the 17th edge.
  task automatic relock(input string tag);
    repeat (16) step();
    chk({tag, "_prelock"}, 32'(rx_lock), 32'd0);
    step();
    chk({tag, "_lock"}, 32'(rx_lock), 32'd1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; clear = 1'b0; genrate_err = 1'b0; zero_rx = 1'b0;
    #3;
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_rx_val", 32'(rx_val), 32'd0);
    chk("rst_lock", 32'(rx_lock), 32'd0);
    chk("rst_err", 32'(rx_error), 32'd0);
    chk("rst_cnt", error_count, 32'd0);
    step(); step();
    reset = 1'b1;
    step();
    chk("idle_tx_valid", 32'(tx_valid), 32'd0);

    // Clean loopback to lock
    start = 1'b1;
    step();
    chk("word1", 32'(tx_data), 32'h0000_FE04);
    chk("tx_valid", 32'(tx_valid), 32'd1);
    step();
    chk("word2", 32'(tx_data), 32'h0000_1851);
    chk("rx_val", 32'(rx_val), 32'd1);
    repeat (15) step();
    chk("lock_c17", 32'(rx_lock), 32'd0);
    step();
    chk("lock_c18", 32'(rx_lock), 32'd1);
    chk("lock_cnt0", error_count, 32'd0);
    repeat (5) step();
    chk("lock_err0", 32'(rx_error), 32'd0);

    // Injection: single pulse, then a long hold gives one error
    genrate_err = 1'b1; step();
    genrate_err = 1'b0; step();
    chk("inj_pulse_cnt", error_count, INJ);
    chk("inj_pulse_err", 32'(rx_error), INJ);
    step();
    chk("inj_pulse_lock", 32'(rx_lock), 32'd1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_cnt", error_count, 32'd0);
    chk("clear_err", 32'(rx_error), 32'd0);
    genrate_err = 1'b1;
    repeat (100) step();
    genrate_err = 1'b0; step(); step();
    chk("inj_hold_cnt", error_count, INJ);
    chk("inj_hold_lock", 32'(rx_lock), 32'd1);
    clear = 1'b1; step(); clear = 1'b0;

    // Saturation
    force dut.error_count = 32'hFFFF_FFFE;
    #1 release dut.error_count;
    zero_rx = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_cnt", error_count, 32'hFFFF_FFFF);
    end
    chk("sat_lock", 32'(rx_lock), 32'd1);
    zero_rx = 1'b0; step();
    chk("sat_hold", error_count, 32'hFFFF_FFFF);
    zero_rx = 1'b1; clear = 1'b1; step();
    zero_rx = 1'b0; clear = 1'b0;
    chk("clr_vs_inc_cnt", error_count, 32'd0);
    chk("clr_vs_inc_err", 32'(rx_error), 32'd0);
    step();

    // Loss of lock on zero words, zero-seed guard, relock
    zero_rx = 1'b1;
    repeat (3) step();
    chk("loss3_lock", 32'(rx_lock), 32'd1);
    chk("loss3_cnt", error_count, 32'd3);
    step();
    chk("loss4_lock", 32'(rx_lock), 32'd0);
    chk("loss4_cnt", error_count, 32'd4);
    chk("loss4_err", 32'(rx_error), 32'd1);
    step(); step();
    chk("seed_zero_cnt", error_count, 32'd4);
    zero_rx = 1'b0;
    relock("relock_zero");

    // start=0 holds status, restart relocks
    start = 1'b0;
    step(); step();
    chk("stop_tx_valid", 32'(tx_valid), 32'd0);
    chk("stop_lock", 32'(rx_lock), 32'd0);
    chk("stop_cnt", error_count, 32'd4);
    chk("stop_err", 32'(rx_error), 32'd1);
    start = 1'b1;
    step();
    relock("relock_start");

    // Async reset while locked with count 5
    zero_rx = 1'b1; step(); zero_rx = 1'b0;
    chk("pre_rst_cnt", error_count, 32'd5);
    #2 reset = 1'b0;
    #1;
    chk("arst_tx_data", 32'(tx_data), 32'd0);
    chk("arst_tx_valid", 32'(tx_valid), 32'd0);
    chk("arst_rx_val", 32'(rx_val), 32'd0);
    chk("arst_lock", 32'(rx_lock), 32'd0);
    chk("arst_err", 32'(rx_error), 32'd0);
    chk("arst_cnt", error_count, 32'd0);
    step(); step();
    reset = 1'b1;
    step();
    chk("post_rst_word1", 32'(tx_data), 32'h0000_FE04);
    relock("relock_rst");
    chk("post_rst_cnt", error_count, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
